instr_encoder_loader: RTL and testbench



---
 rtl/instr_encoder_loader.sv | 152 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Sequential MIPS instruction encoder: packs mnemonic plus fields into a 32-bit word
// and writes it to instruction memory at successive word addresses.
module instr_encoder_loader #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 64,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        mnem,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W-2:0] count,
   output logic              full,
   output logic              err,
   output logic [1:0]        dbg_state
);

   // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
   // fields must be held stable by the producer until that edge.

   localparam logic [ADDR_W-1:0] BASE    = BASE_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-2:0] DEPTH_C = DEPTH[ADDR_W-2:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENC   = 2'd1,
      S_WRITE = 2'd2,
      S_FULL  = 2'd3
   } state_t;

   state_t state, next_state;

   logic [3:0]        cap_mnem;
   logic [4:0]        cap_rs, cap_rt, cap_rd, cap_shamt;
   logic [5:0]        cap_funct;
   logic [15:0]       cap_imm;
   logic [5:0]        opcode;
   logic              legal;
   logic [31:0]       word;
   logic [ADDR_W-2:0] count_inc;

   always_comb begin
      opcode = 6'b000000;
      legal  = 1'b1;
      case (cap_mnem)
         4'd0:    opcode = 6'b000000;
         4'd1:    opcode = 6'b100011;
         4'd2:    opcode = 6'b101011;
         4'd3:    opcode = 6'b000100;
         4'd4:    opcode = 6'b001000;
         4'd5:    opcode = 6'b001100;
         4'd6:    opcode = 6'b001101;
         4'd7:    opcode = 6'b001010;
         default: legal  = 1'b0;
      endcase
   end

   always_comb begin
      if (cap_mnem == 4'd0)
         word = {6'b000000, cap_rs, cap_rt, cap_rd, cap_shamt, cap_funct};
      else
         word = {opcode, cap_rs, cap_rt, cap_imm};
   end

   assign count_inc = count + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      mem_we     = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = S_ENC;
         end
         S_ENC:   next_state = legal ? S_WRITE : S_IDLE;
         S_WRITE: begin
            mem_we     = 1'b1;
            next_state = (count_inc == DEPTH_C) ? S_FULL : S_IDLE;
         end
         S_FULL:  next_state = S_FULL;
         default: next_state = S_IDLE;
      endcase
      // start aborts any in-flight encode or write
      if (start) next_state = S_IDLE;
   end

   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr  <= BASE;
         mem_wdata <= 32'd0;
         count     <= '0;
         full      <= 1'b0;
         err       <= 1'b0;
         cap_mnem  <= 4'd0;
         cap_rs    <= 5'd0;
         cap_rt    <= 5'd0;
         cap_rd    <= 5'd0;
         cap_shamt <= 5'd0;
         cap_funct <= 6'd0;
         cap_imm   <= 16'd0;
      end else if (start) begin
         mem_addr <= BASE;
         count    <= '0;
         full     <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  cap_mnem  <= mnem;
                  cap_rs    <= rs;
                  cap_rt    <= rt;
                  cap_rd    <= rd;
                  cap_shamt <= shamt;
                  cap_funct <= funct;
                  cap_imm   <= imm;
               end
            end
            S_ENC: begin
               if (legal) mem_wdata <= word;
               else       err       <= 1'b1;
            end
            S_WRITE: begin
               count    <= count_inc;
               mem_addr <= mem_addr + ADDR_W'(4);
               if (count_inc == DEPTH_C) full <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader: each instruction is checked cycle by
// cycle against an arithmetic reference encoder and a loader model.
module tb_instr_encoder_loader;

   localparam int ADDR_W    = 8;
   localparam int DEPTH     = 64;
   localparam int BASE_ADDR = 0;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        mnem = '0;
   logic [4:0]        rs = '0, rt = '0, rd = '0, shamt = '0;
   logic [5:0]        funct = '0;
   logic [15:0]       imm = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W-2:0] count;
   logic              full;
   logic              err;
   logic [1:0]        dbg_state;

   instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
      .full(full), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // loader model
   int  exp_addr   = BASE_ADDR;
   int  exp_count  = 0;
   int  exp_writes = 0;
   bit  exp_full   = 0;
   bit  exp_err    = 0;
   int  we_count   = 0;
   int  last_addr  = -1;
   logic [31:0] exp_q[$];

   always @(posedge clk) if (mem_we === 1'b1) we_count++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(int m, int rs_v, int rt_v, int rd_v, int sh_v,
                                            int fn_v, int imm_v);
      int     op_tab[8];
      longint w;
      op_tab = '{0, 35, 43, 4, 8, 12, 13, 10};
      w = longint'(op_tab[m]) * 64'd67108864 + longint'(rs_v) * 2097152
          + longint'(rt_v) * 65536;
      if (m == 0) w = w + rd_v * 2048 + sh_v * 64 + fn_v;
      else        w = w + imm_v;
      return w[31:0];
   endfunction

   task automatic model_clear();
      exp_addr  = BASE_ADDR;
      exp_count = 0;
      exp_full  = 0;
      exp_err   = 0;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge.
   task automatic send(input int m, input int rs_v, input int rt_v, input int rd_v,
                       input int sh_v, input int fn_v, input int imm_v);
      logic [31:0] w;
      mnem = m[3:0]; rs = rs_v[4:0]; rt = rt_v[4:0]; rd = rd_v[4:0];
      shamt = sh_v[4:0]; funct = fn_v[5:0]; imm = imm_v[15:0];
      in_valid = 1'b1;
      check_eq("ready_idle", in_ready, 1'b1);
      if (m < 8) exp_q.push_back(ref_word(m, rs_v, rt_v, rd_v, sh_v, fn_v, imm_v));
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      check_eq("ready_enc", in_ready, 1'b0);
      check_eq("we_enc", mem_we, 1'b0);
      @(negedge clk);
      if (m < 8) begin
         w = exp_q.pop_front();
         check_eq("we_write", mem_we, 1'b1);
         check_eq("addr_write", mem_addr, exp_addr[ADDR_W-1:0]);
         check_eq("wdata_write", mem_wdata, w);
         check_eq("ready_write", in_ready, 1'b0);
         last_addr = mem_addr;
         @(negedge clk);
         exp_writes++;
         exp_count++;
         exp_addr = (exp_addr + 4) % (1 << ADDR_W);
         if (exp_count == DEPTH) exp_full = 1;
         check_eq("we_after", mem_we, 1'b0);
         check_eq("count", count, exp_count[ADDR_W-2:0]);
         check_eq("addr_next", mem_addr, exp_addr[ADDR_W-1:0]);
         check_eq("full", full, exp_full);
         check_eq("ready_back", in_ready, !exp_full);
      end else begin
         exp_err = 1;
         check_eq("ready_illegal", in_ready, 1'b1);
         check_eq("we_illegal", mem_we, 1'b0);
         check_eq("count_illegal", count, exp_count[ADDR_W-2:0]);
      end
      check_eq("err", err, exp_err);
      check_eq("we_total", we_count, exp_writes);
   endtask

   task automatic send_rand(input bit allow_illegal);
      int m;
      if (allow_illegal && $urandom_range(0, 7) == 0) m = $urandom_range(8, 15);
      else                                              m = $urandom_range(0, 7);
      send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535));
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      model_clear();
      check_eq("start_count", count, '0);
      check_eq("start_addr", mem_addr, BASE_ADDR[ADDR_W-1:0]);
      check_eq("start_full", full, 1'b0);
      check_eq("start_err", err, 1'b0);
      check_eq("start_ready", in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_we", mem_we, 1'b0);
      check_eq("rst_addr", mem_addr, BASE_ADDR[ADDR_W-1:0]);
      check_eq("rst_wdata", mem_wdata, 32'd0);
      check_eq("rst_count", count, '0);
      check_eq("rst_full", full, 1'b0);
      check_eq("rst_err", err, 1'b0);
      check_eq("rst_ready", in_ready, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ADDI rs=0 rt=8 imm=5
      send(4, 0, 8, 0, 0, 0, 5);
      check_eq("addi_word", mem_wdata, 32'h20080005);

      // back-to-back R, LW, BEQ
      do_start();
      send(0, 1, 2, 3, 0, 32, 0);
      check_eq("r_word", mem_wdata, 32'h00221820);
      send(1, 10, 9, 0, 0, 0, 4);
      check_eq("lw_word", mem_wdata, 32'h8D490004);
      send(3, 1, 2, 0, 0, 0, 16'hFFFF);
      check_eq("beq_word", mem_wdata, 32'h1022FFFF);

      // illegal then ORI; err stays set
      send(9, 3, 4, 5, 6, 7, 8);
      send(6, 0, 4, 0, 0, 0, 16'h00FF);
      check_eq("ori_word", mem_wdata, 32'h340400FF);
      check_eq("err_sticky", err, 1'b1);

      repeat (30) send_rand(1'b1);

      // fill all DEPTH words
      do_start();
      repeat (DEPTH) send_rand(1'b0);
      check_eq("last_addr", last_addr, 32'hFC);
      check_eq("full_count", count, 7'd64);
      check_eq("full_ready", in_ready, 1'b0);
      for (int i = 0; i < 5; i++) begin
         mnem = $urandom_range(0, 7); rs = $urandom_range(0, 31); imm = $urandom_range(0, 65535);
         in_valid = 1'b1;
         @(negedge clk);
         check_eq("full_hold_ready", in_ready, 1'b0);
         check_eq("full_hold_we", mem_we, 1'b0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("full_we_total", we_count, exp_writes);
      check_eq("full_flag", full, 1'b1);
      do_start();

      // start during ENC aborts the write
      send(4, 1, 1, 0, 0, 0, 1);
      mnem = 4'd6; rs = 5'd2; rt = 5'd3; imm = 16'h1234;
      in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      model_clear();
      check_eq("abort_we", mem_we, 1'b0);
      check_eq("abort_count", count, '0);
      @(negedge clk);
      check_eq("abort_we_total", we_count, exp_writes);
      check_eq("abort_ready", in_ready, 1'b1);

      // reset during WRITE
      send(12, 0, 0, 0, 0, 0, 0);
      send(5, 7, 7, 0, 0, 0, 16'hAAAA);
      mnem = 4'd7; rs = 5'd5; rt = 5'd6; imm = 16'h8000;
      in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_we", mem_we, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("arst_we", mem_we, 1'b0);
      check_eq("arst_addr", mem_addr, BASE_ADDR[ADDR_W-1:0]);
      check_eq("arst_wdata", mem_wdata, 32'd0);
      check_eq("arst_count", count, '0);
      check_eq("arst_err", err, 1'b0);
      check_eq("arst_full", full, 1'b0);
      check_eq("arst_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(negedge clk);
      check_eq("arst_we_total", we_count, exp_writes);
      send_rand(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
